bp_update_queue: RTL and testbench
==================================

# bp_update_queue

Buffers resolved-branch updates committed by the ROB and feeds them to the branch predictor (`tournament_predictor`, `gshare_predictor` or `local_predictor`) at a bounded rate. Up to `N` updates per cycle come in and are compacted into an in-order circular FIFO. At most UPDATE_WIDTH updates per cycle leave as an `ROB_IF_PACKET`. The block sits between ROB commit and the predictor's `rob_if_packet` input. It provides commit backpressure, a hold control for fetch, and sticky overflow detection.

## Interface
- DEPTH, 8: FIFO capacity in update entries; power of two, DEPTH >= `N`.
- UPDATE_WIDTH, 1: maximum updates presented to the predictor per cycle; 1 <= UPDATE_WIDTH <= `N`.
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- rob_in  in  ROB_IF_PACKET  committed branch resolutions; `entries[i].valid` marks a real update, and valid entries may be sparse.
- hold  in  1  when high, no dequeue occurs this cycle.
- bp_out  out  ROB_IF_PACKET  updates to the predictor; only entries[0..UPDATE_WIDTH-1] may be valid.
- rob_stall  out  1  ROB must not present updates this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy (registered).
- overflow  out  1  sticky: valid updates arrived while rob_stall was high.

## Operation
- **Storage**
  - DEPTH entries, each holding PC, resolve_taken and resolve_target.
  - head and tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH.
  - count register is separate, so full and empty are unambiguous.
- **Enqueue**
  - Happens when rob_stall is low.
  - The valid entries of rob_in are compacted in ascending index order and written at tail, tail+1, ... in that order.
  - tail advances by the number of valid entries; an all-invalid rob_in enqueues nothing.
- **Backpressure**
  - rob_stall = (DEPTH - count) < `N`, computed from the registered count only.
  - It does not account for same-cycle dequeue, so it is deliberately conservative.
- **Overflow**
  - If rob_stall is high and any rob_in entry is valid, all of rob_in is dropped.
  - overflow sets to 1 and stays set until reset.
  - FIFO contents are unaffected.
- **Dequeue**
  - When hold is low, k = min(count, UPDATE_WIDTH) oldest entries drive bp_out.entries[0..k-1] with valid=1, in age order.
  - head advances by k.
  - All other bp_out entries are driven with valid=0 and every field 0.
- **Hold**
  - When hold is high, bp_out is all-zero, head is unchanged, and enqueue proceeds normally.
- **Simultaneous events**
  - Enqueue and dequeue in the same cycle are legal.
  - next count = count + enq - deq.
  - An entry enqueued in cycle t is never dequeued in cycle t (no bypass).
- **Output decode**
  - bp_out is combinational from registered FIFO state and hold.
  - It never depends on rob_in.
- **Ordering**
  - Updates reach the predictor in exactly commit order: by ROB index within a cycle, then by cycle.
- **Storage contents**
  - Entry payloads need no reset; only pointers, count and overflow are reset.

## Timing
- **Reset**
  - During the reset cycle: head=0, tail=0, count=0, overflow=0.
  - After the reset edge: bp_out all-zero and rob_stall = (DEPTH < `N`), which is 0 for legal parameters.
- **Reset mid-operation**
  - All queued updates are discarded; the predictor sees no further updates from before reset.
- **Latency**
  - Valid rob_in at edge t appears on bp_out during cycle t+1 at the earliest, provided hold is low and no older entries are pending.
- **Throughput**
  - Sustained drain is UPDATE_WIDTH per cycle.
  - A backlog of B entries drains in ceil(B/UPDATE_WIDTH) unheld cycles.
- **Edge-visible changes**
  - count and overflow change only at clock edges.
  - rob_stall changes in the cycle after count crosses the threshold DEPTH-`N`.
- **Wrap-around**
  - A compacted write group that crosses index DEPTH-1 continues at index 0 with no gap.

## Test plan
1. **Reset then single update.** `N=2, DEPTH=4, UPDATE_WIDTH=1. Reset, then rob_in.entries[1] valid, PC=0x40, taken=1, target=0x80, for one cycle. Required: next cycle bp_out.entries[0] = {valid=1, PC=0x40, taken=1, target=0x80}; count goes 1 then 0; entries[1].valid=0 throughout.
2. **Compaction and order.** Two cycles of two valid updates each: PCs 0x10, 0x14, then 0x18, 0x1C. Required: bp_out PCs over four consecutive cycles are 0x10, 0x14, 0x18, 0x1C.
3. **Full/stall with wrap.** Keep hold high and enqueue 2 per cycle. Required: rob_stall=1 once count=3 or 4; drop hold and count decrements by 1 per cycle; rob_stall=0 once count<=2; a refill crosses index 3→0 with correct output order.
4. **Overflow.** Present a valid update while rob_stall=1. Required: overflow=1 from the next cycle; count unchanged; queued contents still drain in order; overflow stays 1 until reset.
5. **Simultaneous enqueue/dequeue.** count=2, hold low, 2 valid updates enqueued. Required: count=3 the next cycle; the oldest entry is on bp_out; the new entries appear only after the older entries have drained.
6. **Reset mid-drain and UPDATE_WIDTH=2.** Reset with 3 entries queued. Required: bp_out all-zero and count=0 afterward. With UPDATE_WIDTH=2, 3 queued entries emit 2 then 1 valid per cycle.

Source files
------------

// File: rtl/bp_update_queue.sv
// Branch-predictor update queue: compacts up to N committed branch resolutions per
// cycle into a circular FIFO and releases up to UPDATE_WIDTH per cycle in commit order.
package bp_update_queue_pkg;
  localparam int N    = 2;
  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } bp_entry_t;

  typedef struct packed {
    bp_entry_t [N-1:0] entries;
  } ROB_IF_PACKET;
endpackage

module bp_update_queue
  import bp_update_queue_pkg::*;
#(
  parameter int  DEPTH        = 8,
  parameter int  UPDATE_WIDTH = 1,
  localparam int PW           = $clog2(DEPTH),
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  ROB_IF_PACKET  rob_in,
  input  logic          hold,
  output ROB_IF_PACKET  bp_out,
  output logic          rob_stall,
  output logic [CW-1:0] count,
  output logic          overflow
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } slot_t;

  slot_t         r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic [CW-1:0] w_enq_cnt;
  logic [CW-1:0] w_deq_cnt;
  logic [PW-1:0] w_slot [N];
  logic          w_any_valid;
  logic          w_enq_en;

  // Handshake: while rob_stall is high the ROB must present no valid entries; any valid
  // entry seen then is dropped whole and latches overflow. rob_stall looks only at the
  // registered count, so it ignores a same-cycle dequeue and may stall one cycle early.
  assign rob_stall = (DEPTH - int'(r_count)) < N;
  assign w_enq_en  = !rob_stall && w_any_valid;
  assign count     = r_count;
  assign overflow  = r_overflow;

  // Each valid entry lands at tail plus the number of valid entries below it.
  always_comb begin
    w_enq_cnt   = '0;
    w_any_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_slot[i] = r_tail + w_enq_cnt[PW-1:0];
      if (rob_in.entries[i].valid) begin
        w_enq_cnt   = w_enq_cnt + 1'b1;
        w_any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    w_deq_cnt = '0;
    if (!hold) begin
      w_deq_cnt = (r_count < CW'(UPDATE_WIDTH)) ? r_count : CW'(UPDATE_WIDTH);
    end
  end

  always_comb begin
    bp_out = '0;
    for (int j = 0; j < UPDATE_WIDTH; j++) begin
      if (CW'(j) < w_deq_cnt) begin
        bp_out.entries[j].valid  = 1'b1;
        bp_out.entries[j].pc     = r_mem[r_head + PW'(j)].pc;
        bp_out.entries[j].taken  = r_mem[r_head + PW'(j)].taken;
        bp_out.entries[j].target = r_mem[r_head + PW'(j)].target;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_head  <= r_head + w_deq_cnt[PW-1:0];
      r_count <= r_count + (w_enq_en ? w_enq_cnt : '0) - w_deq_cnt;
      if (w_enq_en) begin
        r_tail <= r_tail + w_enq_cnt[PW-1:0];
      end
      if (rob_stall && w_any_valid) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Payload storage carries no reset; only pointers and count define what is live.
  always_ff @(posedge clock) begin
    if (!reset && w_enq_en) begin
      for (int i = 0; i < N; i++) begin
        if (rob_in.entries[i].valid) begin
          r_mem[w_slot[i]].pc     <= rob_in.entries[i].pc;
          r_mem[w_slot[i]].taken  <= rob_in.entries[i].taken;
          r_mem[w_slot[i]].target <= rob_in.entries[i].target;
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_update_queue.sv
// Bench for bp_update_queue: a directed vector table, hand sequences for reset/wide drain,
// and random traffic, all checked against a queue-based reference model.
module tb_bp_update_queue;
  import bp_update_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int EW    = $bits(bp_entry_t);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         hold;
  ROB_IF_PACKET rob_in;
  ROB_IF_PACKET bp_out_a, bp_out_b;
  logic         stall_a, stall_b, ovf_a, ovf_b;
  logic [CW-1:0] count_a, count_b;

  bp_update_queue #(.DEPTH(DEPTH), .UPDATE_WIDTH(1)) dut_a (
    .clock(clock), .reset(reset), .rob_in(rob_in), .hold(hold),
    .bp_out(bp_out_a), .rob_stall(stall_a), .count(count_a), .overflow(ovf_a)
  );

  bp_update_queue #(.DEPTH(DEPTH), .UPDATE_WIDTH(2)) dut_b (
    .clock(clock), .reset(reset), .rob_in(rob_in), .hold(hold),
    .bp_out(bp_out_b), .rob_stall(stall_b), .count(count_b), .overflow(ovf_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_qa[$];
  logic [EW-1:0] exp_qb[$];
  logic m_ovf_a = 1'b0;
  logic m_ovf_b = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic bp_entry_t mk_ent(input logic v, input logic [31:0] pc);
    bp_entry_t e;
    e.valid  = v;
    e.pc     = pc;
    e.taken  = ~pc[2];
    e.target = pc << 1;
    return e;
  endfunction

  function automatic ROB_IF_PACKET mk_in(input logic [1:0] vld, input logic [31:0] p0,
                                         input logic [31:0] p1);
    ROB_IF_PACKET p;
    p.entries[0] = mk_ent(vld[0], p0);
    p.entries[1] = mk_ent(vld[1], p1);
    return p;
  endfunction

  // Oldest min(len, uw) queued updates, in age order, unless held.
  function automatic ROB_IF_PACKET model_out(input logic [EW-1:0] q[$], input int uw,
                                             input logic h);
    ROB_IF_PACKET p;
    int k;
    p = '0;
    k = h ? 0 : ((q.size() < uw) ? q.size() : uw);
    for (int j = 0; j < k; j++) p.entries[j] = bp_entry_t'(q[j]);
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input logic rst, input logic h, input ROB_IF_PACKET in);
    @(negedge clock);
    reset  = rst;
    hold   = h;
    rob_in = in;
    #1;
    chk("bp_out_a", 256'(bp_out_a), 256'(model_out(exp_qa, 1, h)));
    chk("stall_a",  256'(stall_a),  256'((DEPTH - exp_qa.size()) < N));
    chk("count_a",  256'(count_a),  256'(exp_qa.size()));
    chk("ovf_a",    256'(ovf_a),    256'(m_ovf_a));
    chk("bp_out_b", 256'(bp_out_b), 256'(model_out(exp_qb, 2, h)));
    chk("stall_b",  256'(stall_b),  256'((DEPTH - exp_qb.size()) < N));
    chk("count_b",  256'(count_b),  256'(exp_qb.size()));
    chk("ovf_b",    256'(ovf_b),    256'(m_ovf_b));
  endtask

  task automatic advance();
    logic any_v;
    logic st;
    int   k;
    @(posedge clock);
    any_v = 1'b0;
    for (int i = 0; i < N; i++) any_v |= rob_in.entries[i].valid;
    if (reset) begin
      exp_qa.delete(); exp_qb.delete();
      m_ovf_a = 1'b0;  m_ovf_b = 1'b0;
    end else begin
      st = (DEPTH - exp_qa.size()) < N;
      k  = hold ? 0 : ((exp_qa.size() < 1) ? exp_qa.size() : 1);
      for (int j = 0; j < k; j++) void'(exp_qa.pop_front());
      if (st) begin
        if (any_v) m_ovf_a = 1'b1;
      end else begin
        for (int i = 0; i < N; i++)
          if (rob_in.entries[i].valid) exp_qa.push_back(EW'(rob_in.entries[i]));
      end
      st = (DEPTH - exp_qb.size()) < N;
      k  = hold ? 0 : ((exp_qb.size() < 2) ? exp_qb.size() : 2);
      for (int j = 0; j < k; j++) void'(exp_qb.pop_front());
      if (st) begin
        if (any_v) m_ovf_b = 1'b1;
      end else begin
        for (int i = 0; i < N; i++)
          if (rob_in.entries[i].valid) exp_qb.push_back(EW'(rob_in.entries[i]));
      end
    end
  endtask

  // ---------------- directed vector table (UPDATE_WIDTH=1 instance) ----------------
  typedef struct {
    logic [1:0]  vld;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        h;
    logic        ev;
    logic [31:0] epc;
    int          ecnt;
    logic        estall;
    logic        eovf;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mkv(input logic [1:0] vld, input logic [31:0] pc0,
                               input logic [31:0] pc1, input logic h, input logic ev,
                               input logic [31:0] epc, input int ecnt, input logic estall,
                               input logic eovf);
    vec_t v;
    v.vld = vld; v.pc0 = pc0; v.pc1 = pc1; v.h = h; v.ev = ev; v.epc = epc;
    v.ecnt = ecnt; v.estall = estall; v.eovf = eovf;
    return v;
  endfunction

  initial begin
    logic [1:0]  rv;
    logic        rh, rr;
    reset  = 1'b1;
    hold   = 1'b0;
    rob_in = '0;

    // single update on entries[1]; taken=1 target=0x80 for pc 0x40
    tbl[0]  = mkv(2'b10, 32'h0,  32'h40, 0, 0, 32'h0,  0, 0, 0);
    tbl[1]  = mkv(2'b00, 32'h0,  32'h0,  0, 1, 32'h40, 1, 0, 0);
    tbl[2]  = mkv(2'b00, 32'h0,  32'h0,  0, 0, 32'h0,  0, 0, 0);
    // two pairs drain in commit order
    tbl[3]  = mkv(2'b11, 32'h10, 32'h14, 0, 0, 32'h0,  0, 0, 0);
    tbl[4]  = mkv(2'b11, 32'h18, 32'h1C, 0, 1, 32'h10, 2, 0, 0);
    tbl[5]  = mkv(2'b00, 32'h0,  32'h0,  0, 1, 32'h14, 3, 1, 0);
    tbl[6]  = mkv(2'b00, 32'h0,  32'h0,  0, 1, 32'h18, 2, 0, 0);
    tbl[7]  = mkv(2'b00, 32'h0,  32'h0,  0, 1, 32'h1C, 1, 0, 0);
    tbl[8]  = mkv(2'b00, 32'h0,  32'h0,  0, 0, 32'h0,  0, 0, 0);
    // fill under hold; this group wraps from index 3 to 0
    tbl[9]  = mkv(2'b11, 32'h20, 32'h24, 1, 0, 32'h0,  0, 0, 0);
    tbl[10] = mkv(2'b11, 32'h28, 32'h2C, 1, 0, 32'h0,  2, 0, 0);
    tbl[11] = mkv(2'b00, 32'h0,  32'h0,  1, 0, 32'h0,  4, 1, 0);
    // valid input while stalled is dropped and latches overflow
    tbl[12] = mkv(2'b01, 32'h99, 32'h0,  1, 0, 32'h0,  4, 1, 0);
    tbl[13] = mkv(2'b00, 32'h0,  32'h0,  0, 1, 32'h20, 4, 1, 1);
    tbl[14] = mkv(2'b00, 32'h0,  32'h0,  0, 1, 32'h24, 3, 1, 1);
    // simultaneous enqueue and dequeue at count 2
    tbl[15] = mkv(2'b11, 32'h30, 32'h34, 0, 1, 32'h28, 2, 0, 1);
    tbl[16] = mkv(2'b00, 32'h0,  32'h0,  0, 1, 32'h2C, 3, 1, 1);
    tbl[17] = mkv(2'b00, 32'h0,  32'h0,  0, 1, 32'h30, 2, 0, 1);
    tbl[18] = mkv(2'b00, 32'h0,  32'h0,  0, 1, 32'h34, 1, 0, 1);
    tbl[19] = mkv(2'b00, 32'h0,  32'h0,  0, 0, 32'h0,  0, 0, 1);

    apply(1'b1, 1'b0, '0);
    advance();

    for (int i = 0; i < 20; i++) begin
      apply(1'b0, tbl[i].h, mk_in(tbl[i].vld, tbl[i].pc0, tbl[i].pc1));
      chk($sformatf("tbl%0d_e0", i), 256'(bp_out_a.entries[0]),
          256'(tbl[i].ev ? mk_ent(1'b1, tbl[i].epc) : bp_entry_t'('0)));
      chk($sformatf("tbl%0d_e1", i), 256'(bp_out_a.entries[1]), 256'(0));
      chk($sformatf("tbl%0d_cnt", i), 256'(count_a), 256'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_stall", i), 256'(stall_a), 256'(tbl[i].estall));
      chk($sformatf("tbl%0d_ovf", i), 256'(ovf_a), 256'(tbl[i].eovf));
      advance();
    end

    // reset with three entries queued discards them and clears overflow
    apply(1'b0, 1'b1, mk_in(2'b11, 32'h50, 32'h54)); advance();
    apply(1'b0, 1'b1, mk_in(2'b01, 32'h58, 32'h0));  advance();
    apply(1'b0, 1'b1, '0);
    chk("pre_rst_cnt_b", 256'(count_b), 256'(3));
    advance();
    apply(1'b1, 1'b0, '0); advance();
    apply(1'b0, 1'b0, '0);
    chk("post_rst_out_a", 256'(bp_out_a), 256'(0));
    chk("post_rst_out_b", 256'(bp_out_b), 256'(0));
    chk("post_rst_cnt_b", 256'(count_b), 256'(0));
    chk("post_rst_ovf_a", 256'(ovf_a), 256'(0));
    advance();

    // three queued entries leave the two-wide instance as 2 then 1
    apply(1'b0, 1'b1, mk_in(2'b11, 32'h60, 32'h64)); advance();
    apply(1'b0, 1'b1, mk_in(2'b01, 32'h68, 32'h0));  advance();
    apply(1'b0, 1'b0, '0);
    chk("w2_c0_e0", 256'(bp_out_b.entries[0]), 256'(mk_ent(1'b1, 32'h60)));
    chk("w2_c0_e1", 256'(bp_out_b.entries[1]), 256'(mk_ent(1'b1, 32'h64)));
    advance();
    apply(1'b0, 1'b0, '0);
    chk("w2_c1_e0", 256'(bp_out_b.entries[0]), 256'(mk_ent(1'b1, 32'h68)));
    chk("w2_c1_e1", 256'(bp_out_b.entries[1]), 256'(0));
    advance();
    apply(1'b0, 1'b0, '0);
    chk("w2_c2_out", 256'(bp_out_b), 256'(0));
    advance();

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      rr = ($urandom_range(0, 99) == 0);
      rh = ($urandom_range(0, 3) == 0);
      rv = 2'($urandom_range(0, 3));
      apply(rr, rh, mk_in(rv, {$urandom_range(0, 65535), 2'b00},
                          {$urandom_range(0, 65535), 2'b00}));
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
